// File: rtl/apb_slave_mem_ws.sv
// apb_slave_mem_ws: APB4 scratch RAM slave with byte-lane strobes, programmable
// wait states and PSLVERR on range, read-strobe and protocol violations.
module apb_slave_mem_ws #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NLANES = DATA_WIDTH / 8;
    localparam int LSB    = (NLANES > 1) ? $clog2(NLANES) : 0;
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0]            WS      = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                                 state;
    logic [3:0]                             cnt;
    logic [MEM_DEPTH-1:0][DATA_WIDTH-1:0]   mem;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [IDX_W-1:0]      idx;
    logic                  range_err;
    logic                  in_access;
    logic                  viol;
    logic                  done;
    logic                  strb_err;
    logic                  wr_en;
    logic                  rd_ok;

    // The state register records the phase of the previous cycle, so a cycle
    // with PSEL & PENABLE is a legal access only if SETUP or ACCESS preceded it.
    always_comb begin
        word_idx  = PADDR >> LSB;
        idx       = word_idx[IDX_W-1:0];
        range_err = (word_idx >= DEPTH_A);
        in_access = PSEL & PENABLE & (state != IDLE);
        viol      = PSEL & PENABLE & (state == IDLE);
        done      = in_access & (cnt == WS);
        strb_err  = ~PWRITE & (PSTRB != '0);
        wr_en     = done & PWRITE & ~range_err;
        rd_ok     = done & ~PWRITE & ~range_err & ~strb_err;
        PREADY    = ~PRESET & (viol | done);
        PSLVERR   = ~PRESET & (viol | (done & (range_err | strb_err)));
        PRDATA    = (~PRESET & rd_ok) ? mem[idx] : '0;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
            cnt   <= '0;
            mem   <= '0;
        end else begin
            if (wr_en) begin
                for (int b = 0; b < NLANES; b++) begin
                    if (PSTRB[b]) mem[idx][8*b +: 8] <= PWDATA[8*b +: 8];
                end
            end
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    state <= (PSEL & ~PENABLE) ? SETUP : IDLE;
                end
                default: begin
                    if (!PSEL || done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!PENABLE) begin
                        state <= SETUP;
                        cnt   <= '0;
                    end else begin
                        state <= ACCESS;
                        cnt   <= cnt + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_mem_ws.sv
// Bench for apb_slave_mem_ws: a 2-wait-state, 16-word instance checked against
// a word-array reference model, plus a zero-wait instance for back-to-back timing.
module tb_apb_slave_mem_ws;

    logic        PCLK = 1'b0;
    logic        PRESET;
    always #5 PCLK = ~PCLK;

    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;

    logic        b_psel, b_penable, b_pwrite;
    logic [31:0] b_paddr, b_pwdata, b_prdata;
    logic [3:0]  b_pstrb;
    logic        b_pready, b_pslverr;

    int tests = 0;
    int fails = 0;
    logic [31:0] model [16];

    apb_slave_mem_ws #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16), .WAIT_STATES(2)) u_ws (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata),
        .PREADY(pready), .PSLVERR(pslverr));

    apb_slave_mem_ws #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16), .WAIT_STATES(0)) u_zw (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite),
        .PADDR(b_paddr), .PWDATA(b_pwdata), .PSTRB(b_pstrb), .PRDATA(b_prdata),
        .PREADY(b_pready), .PSLVERR(b_pslverr));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: word index, range/strobe error rules, byte-lane merge.
    task automatic model_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [31:0] rd, output logic err);
        logic [31:0] w;
        logic        rerr;
        w    = addr / 4;
        rerr = (w >= 16);
        rd   = 32'h0;
        if (wr) begin
            err = rerr;
            if (!rerr)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model[w[3:0]][8*b +: 8] = data[8*b +: 8];
        end else begin
            err = rerr || (strb != 4'h0);
            if (!err) rd = model[w[3:0]];
        end
    endtask

    task automatic apb_a(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic [31:0] rd, output logic err,
                         output int waits);
        logic ok;
        ok = 1'b0; waits = 0; rd = 32'h0; err = 1'b0;
        @(negedge PCLK);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        #2 check("setup_pready", 32'(pready), 32'h0);
        @(negedge PCLK);
        penable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (pready) begin
                ok  = 1'b1;
                rd  = prdata;
                err = pslverr;
                break;
            end
            check("wait_prdata", prdata, 32'h0);
            waits++;
            @(negedge PCLK);
        end
        check("ready_timeout", 32'(ok), 32'h1);
        @(negedge PCLK);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          waits;
        apb_a(wr, addr, data, strb, rd, err, waits);
        model_xfer(wr, addr, data, strb, exp_rd, exp_err);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_waits"}, 32'(waits), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [31:0] bdata [4];
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;

        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        PRESET = 1'b1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
        b_psel = 1'b0; b_penable = 1'b0; b_pwrite = 1'b0; b_paddr = 32'h0; b_pwdata = 32'h0; b_pstrb = 4'h0;

        // Outputs held inactive during reset even with PSEL/PENABLE asserted
        #3;
        check("rst_pready", 32'(pready), 32'h0);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        check("rst_prdata", prdata, 32'h0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0; psel = 1'b0; penable = 1'b0;

        xfer("rd_after_rst", 1'b0, 32'h0C, 32'h0, 4'h0, rd, err);
        check("rd_after_rst_val", rd, 32'h0);

        xfer("wr_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err);
        xfer("wr_lane2", 1'b1, 32'h10, 32'h00AA0000, 4'h4, rd, err);
        xfer("rd_merge", 1'b0, 32'h10, 32'h0, 4'h0, rd, err);
        check("rd_merge_val", rd, 32'hDEAABEEF);

        xfer("wr_word0", 1'b1, 32'h00, 32'h11223344, 4'hF, rd, err);
        xfer("wr_range", 1'b1, 32'h40, 32'h12345678, 4'hF, rd, err);
        check("wr_range_slverr", 32'(err), 32'h1);
        xfer("rd_word0", 1'b0, 32'h00, 32'h0, 4'h0, rd, err);
        check("rd_word0_val", rd, 32'h11223344);

        xfer("rd_strb", 1'b0, 32'h10, 32'h0, 4'h1, rd, err);
        check("rd_strb_slverr", 32'(err), 32'h1);
        xfer("wr_nostrb", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, err);

        // Access phase without a preceding setup
        @(negedge PCLK);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        #2;
        check("prot_pready", 32'(pready), 32'h1);
        check("prot_pslverr", 32'(pslverr), 32'h1);
        check("prot_prdata", prdata, 32'h0);
        @(negedge PCLK);
        psel = 1'b0; penable = 1'b0;
        xfer("rd_after_prot", 1'b0, 32'h10, 32'h0, 4'h0, rd, err);
        check("rd_after_prot_val", rd, 32'hDEAABEEF);

        // Reset during the second wait cycle of a write
        @(negedge PCLK);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(negedge PCLK);
        penable = 1'b1;
        @(negedge PCLK);
        #2 PRESET = 1'b1;
        #1 check("midrst_pready", 32'(pready), 32'h0);
        check("midrst_pslverr", 32'(pslverr), 32'h0);
        @(negedge PCLK);
        #2 check("midrst_hold_pready", 32'(pready), 32'h0);
        @(negedge PCLK);
        PRESET = 1'b0; psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        xfer("rd_04_after_rst", 1'b0, 32'h04, 32'h0, 4'h0, rd, err);
        check("rd_04_after_rst_val", rd, 32'h0);
        xfer("rd_10_after_rst", 1'b0, 32'h10, 32'h0, 4'h0, rd, err);

        // Randomised traffic including unaligned and out-of-range addresses
        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 79));
            if (wr) strb = 4'($urandom_range(0, 15));
            else    strb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            xfer("rand", wr, addr, $urandom, strb, rd, err);
        end

        // Zero-wait instance: back-to-back transfers every two cycles
        for (int k = 0; k < 4; k++) begin
            bdata[k] = $urandom;
            @(negedge PCLK);
            b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 32'(4*k);
            b_pwdata = bdata[k]; b_pstrb = 4'hF;
            #2 check("b2b_wr_setup_pready", 32'(b_pready), 32'h0);
            @(negedge PCLK);
            b_penable = 1'b1;
            #2 check("b2b_wr_access_pready", 32'(b_pready), 32'h1);
            check("b2b_wr_slverr", 32'(b_pslverr), 32'h0);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge PCLK);
            b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b0; b_paddr = 32'(4*k); b_pstrb = 4'h0;
            #2 check("b2b_rd_setup_pready", 32'(b_pready), 32'h0);
            @(negedge PCLK);
            b_penable = 1'b1;
            #2 check("b2b_rd_access_pready", 32'(b_pready), 32'h1);
            check("b2b_rd_data", b_prdata, bdata[k]);
        end
        // Read-after-write to the same word in consecutive transfers
        @(negedge PCLK);
        b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 32'h08;
        b_pwdata = 32'hA5A55A5A; b_pstrb = 4'hF;
        @(negedge PCLK);
        b_penable = 1'b1;
        #2 check("raw_wr_pready", 32'(b_pready), 32'h1);
        @(negedge PCLK);
        b_penable = 1'b0; b_pwrite = 1'b0; b_pstrb = 4'h0;
        @(negedge PCLK);
        b_penable = 1'b1;
        #2 check("raw_rd_pready", 32'(b_pready), 32'h1);
        check("raw_rd_data", b_prdata, 32'hA5A55A5A);
        @(negedge PCLK);
        b_psel = 1'b0; b_penable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
